// File: rtl/core_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_boot_ctrl
// Purpose  : Boot/run sequencer for the core. Streams a program image from the
//            host into the instruction and data memories, holds the core in
//            reset for RESET_CYCLES, runs it until a halt byte appears on the
//            UART, and counts run cycles.
// Options  : CORE_BOOT_WATCHDOG_EN - abort a run to ERR after WDT_LIMIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module core_boot_ctrl #(
  parameter int unsigned INSN_DEPTH   = 12,
  parameter int unsigned DATA_DEPTH   = 12,
  parameter int unsigned RESET_CYCLES = 4,
  parameter logic [7:0]  HALT_CHAR    = 8'h04,
  parameter logic [31:0] WDT_LIMIT    = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  output logic        host_ready,
  output logic [31:0] insn_addr,
  output logic [31:0] insn_din,
  output logic        insn_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_din,
  output logic        data_we,
  output logic        core_reset,
  output logic        run,
  input  logic [31:0] uart_dout,
  input  logic        uart_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycles
);

  // Word counter is one bit wider than the larger depth so a full image fits.
  localparam int unsigned CW        = ((INSN_DEPTH > DATA_DEPTH) ? INSN_DEPTH : DATA_DEPTH) + 1;
  localparam logic [32:0] INSN_MAX  = 33'd1 << INSN_DEPTH;
  localparam logic [32:0] DATA_MAX  = 33'd1 << DATA_DEPTH;
  localparam logic [7:0]  RST_LAST  = 8'(RESET_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INSN_LEN  = 4'd1,
    S_INSN_LOAD = 4'd2,
    S_DATA_LEN  = 4'd3,
    S_DATA_LOAD = 4'd4,
    S_CORE_RST  = 4'd5,
    S_RUN       = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [7:0]    rst_cnt_q, rst_cnt_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          insn_we_q, insn_we_d;
  logic [31:0]   insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
  logic          data_we_q, data_we_d;
  logic [31:0]   data_addr_q, data_addr_d, data_din_q, data_din_d;

  logic hs;
  logic last_word;
  logic halt;
  logic unused_uart_hi;

  // Only the low byte of the UART word carries the character.
  assign unused_uart_hi = ^uart_dout[31:8];

  assign host_ready = (state_q == S_INSN_LEN) || (state_q == S_INSN_LOAD) ||
                      (state_q == S_DATA_LEN) || (state_q == S_DATA_LOAD);
  // A word offered in the abort cycle is discarded, so it never produces a strobe.
  assign hs         = host_valid && host_ready && !abort;
  assign last_word  = ((cnt_q + CW'(1)) == len_q);
  assign halt       = uart_we && (uart_dout[7:0] == HALT_CHAR);

  assign run        = (state_q == S_RUN);
  assign core_reset = (state_q != S_RUN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign cycles     = cycles_q;
  assign insn_we    = insn_we_q;
  assign insn_addr  = insn_addr_q;
  assign insn_din   = insn_din_q;
  assign data_we    = data_we_q;
  assign data_addr  = data_addr_q;
  assign data_din   = data_din_q;

  // Next-state, counters and registered write-port values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    rst_cnt_d   = rst_cnt_q;
    cycles_d    = cycles_q;
    insn_we_d   = 1'b0;
    insn_addr_d = insn_addr_q;
    insn_din_d  = insn_din_q;
    data_we_d   = 1'b0;
    data_addr_d = data_addr_q;
    data_din_d  = data_din_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d  = S_INSN_LEN;
            cycles_d = 32'd0;
          end
        end
        S_INSN_LEN: begin
          if (hs) begin
            cnt_d = '0;
            len_d = host_data[CW-1:0];
            if ({1'b0, host_data} > INSN_MAX) state_d = S_ERR;
            else if (host_data == 32'd0)      state_d = S_DATA_LEN;
            else                              state_d = S_INSN_LOAD;
          end
        end
        S_INSN_LOAD: begin
          if (hs) begin
            insn_we_d   = 1'b1;
            insn_addr_d = 32'({cnt_q, 2'b00});
            insn_din_d  = host_data;
            cnt_d       = cnt_q + CW'(1);
            if (last_word) state_d = S_DATA_LEN;
          end
        end
        S_DATA_LEN: begin
          if (hs) begin
            cnt_d     = '0;
            len_d     = host_data[CW-1:0];
            rst_cnt_d = 8'd0;
            if ({1'b0, host_data} > DATA_MAX) state_d = S_ERR;
            else if (host_data == 32'd0)      state_d = S_CORE_RST;
            else                              state_d = S_DATA_LOAD;
          end
        end
        S_DATA_LOAD: begin
          if (hs) begin
            data_we_d   = 1'b1;
            data_addr_d = 32'({cnt_q, 2'b00});
            data_din_d  = host_data;
            cnt_d       = cnt_q + CW'(1);
            rst_cnt_d   = 8'd0;
            if (last_word) state_d = S_CORE_RST;
          end
        end
        S_CORE_RST: begin
          rst_cnt_d = rst_cnt_q + 8'd1;
          if (rst_cnt_q == RST_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          // The halt cycle itself is counted.
          if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
          if (halt) state_d = S_DONE;
`ifdef CORE_BOOT_WATCHDOG_EN
          else if (cycles_q == WDT_LIMIT) state_d = S_ERR;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      rst_cnt_q   <= 8'd0;
      cycles_q    <= 32'd0;
      insn_we_q   <= 1'b0;
      insn_addr_q <= 32'd0;
      insn_din_q  <= 32'd0;
      data_we_q   <= 1'b0;
      data_addr_q <= 32'd0;
      data_din_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rst_cnt_q   <= rst_cnt_d;
      cycles_q    <= cycles_d;
      insn_we_q   <= insn_we_d;
      insn_addr_q <= insn_addr_d;
      insn_din_q  <= insn_din_d;
      data_we_q   <= data_we_d;
      data_addr_q <= data_addr_d;
      data_din_q  <= data_din_d;
    end
  end

endmodule
`default_nettype wire
